// File: rtl/fifo_ctrl_if.sv
// Bus between the FIFO controller and its host: write/read strobes, data,
// fill-level flags and sticky error flags.
interface fifo_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int LW    = 5
);
    // Strobes: wr_en and rd_en are single-cycle requests with no ready
    // handshake. A write is accepted when full is low at the same edge, and a
    // read when empty is low. A refused request changes nothing except the
    // matching sticky error flag.
    logic             wr_en;
    logic [WIDTH-1:0] din;
    logic             rd_en;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LW-1:0]    level;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/fifo_ctrl_p.sv
// Parametrised single-clock FIFO with thresholds, a fill level, sticky error
// flags and a selectable registered or first-word-fall-through read port.
module fifo_ctrl_p #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    parameter int LW       = $clog2(DEPTH + 1)
) (
    input logic       clk,
    input logic       rst,
    fifo_ctrl_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic             udf_q;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;

    assign full_w  = (level_q == LW'(DEPTH));
    assign empty_w = (level_q == '0);
    // Acceptance looks only at the current level, so a same-cycle pop never
    // makes room for a write and a same-cycle write never feeds a read.
    assign wr_acc  = bus.wr_en & ~full_w;
    assign rd_acc  = bus.rd_en & ~empty_w;

    // Storage is never reset; a write in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            // Pointers wrap explicitly because DEPTH need not be a power of two.
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            // A new error in the same cycle as clr_err keeps the flag set.
            if (bus.wr_en && full_w) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (bus.rd_en && empty_w) begin
                udf_q <= 1'b1;
            end else if (bus.clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.dout       = empty_w ? '0 : mem[rd_ptr];
            assign bus.dout_valid = ~empty_w;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            logic             dv_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign bus.dout       = dout_q;
            assign bus.dout_valid = dv_q;
        end
    endgenerate

    assign bus.full         = full_w;
    assign bus.empty        = empty_w;
    assign bus.almost_full  = (level_q >= LW'(AF_LEVEL));
    assign bus.almost_empty = (level_q <= LW'(AE_LEVEL));
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: doc/fifo_ctrl_p.md
# fifo_ctrl_p

Parametrised synchronous FIFO for the UART datapath, sitting between the byte receiver/transmitter and the host-side logic on a single clock domain. It generalises the team's 8x8 buffer to arbitrary width and depth, including non-power-of-two depths. It adds programmable almost-full/almost-empty thresholds, a fill-level output, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode. Read and write strobes are single-cycle, pre-conditioned pulses; no debouncing or edge detection is done inside.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage words (>=2, any integer)
- AF_LEVEL, DEPTH-2, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)
- FWFT, 0, read mode: 0 = registered read, 1 = first-word fall-through
- LW, $clog2(DEPTH+1), derived width of the level output; not to be overridden

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request, one word per cycle high
- din  in  WIDTH  write data, sampled when wr_en is high
- rd_en  in  1  read/pop request, one word per cycle high
- clr_err  in  1  clears overflow and underflow
- dout  out  WIDTH  read data
- dout_valid  out  1  dout carries a valid word (meaning depends on FWFT)
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  LW  number of stored words, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- Write accept: wr_en & ~full. The word is stored at wr_ptr, and wr_ptr advances. A pop in the same cycle does not free space for that write.
- Read accept: rd_en & ~empty. The word at rd_ptr is consumed, and rd_ptr advances. A same-cycle write into an empty FIFO does not make the read valid.
- Pointers are width $clog2(DEPTH) and wrap explicitly from DEPTH-1 to 0. They never rely on natural binary rollover.
- Level update: +1 on write only, -1 on read only, unchanged when both are accepted or neither is. Level never exceeds DEPTH or drops below 0.
- full, empty, almost_full and almost_empty are combinational from the level register.
- FWFT=0:
  - On an accepted read, dout loads mem[rd_ptr] on that edge, and dout_valid is high for exactly the following cycle.
  - dout holds its last value otherwise.
- FWFT=1:
  - dout continuously presents mem[rd_ptr], with dout_valid = ~empty.
  - dout is forced to 0 when empty.
  - rd_en pops the head, and the next word appears the cycle after.
- overflow sets on wr_en & full; underflow sets on rd_en & empty. Both hold until clr_err or rst.
- When set and clr_err occur in the same cycle, the set wins.
- Rejected accesses change no pointer, level or data.
- Reset (rst high at an edge) has priority over all else:
  - wr_ptr, rd_ptr and level are set to 0.
  - dout = 0, dout_valid = 0, overflow = 0, underflow = 0.
  - Resulting outputs: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-stream discards all stored words.

## Timing
- Write latency (FWFT=1): a word written into an empty FIFO at edge N is visible on dout with dout_valid = 1 after edge N, i.e. in cycle N+1.
- Read latency (FWFT=0): rd_en sampled at edge N gives dout/dout_valid valid after edge N, for one cycle.
- Flags and level reflect all accesses accepted at edge N, from after edge N onward. There are no extra pipeline stages.
- Full throughput: one write and one read per cycle, sustained indefinitely at any level 1..DEPTH-1.

## Test plan
- Fill and wrap, DEPTH=5, FWFT=0:
  - Write 0x01..0x05: full = 1, level = 5, almost_full = 1 (AF=3).
  - Read 5: outputs 0x01..0x05 in order, each with a one-cycle dout_valid; then empty = 1.
  - Write 3 more and read 3 more: correct order across the pointer wrap 4 -> 0.
- Overflow/underflow:
  - Write while full: overflow = 1, level stays 5, stored data unchanged.
  - Read while empty: underflow = 1, dout unchanged.
  - clr_err for one cycle: both flags clear.
  - clr_err together with a new full-write: overflow stays 1.
- Simultaneous access:
  - At level 2, wr_en & rd_en for 10 cycles: level stays 2, data order preserved.
  - At full with both strobes: read accepted, write rejected, overflow = 1, level = 4.
  - At empty with both strobes: write accepted, underflow = 1, level = 1.
- FWFT=1, DEPTH=4:
  - Write 0xA5 into empty: next cycle dout = 0xA5, dout_valid = 1.
  - Pop: dout = 0, dout_valid = 0.
  - Write 0x11 and 0x22: dout shows 0x11 until popped, then 0x22.
- Thresholds, DEPTH=16, AE=2, AF=14:
  - Step level 0..16..0 and check almost_empty at levels 0..2 and almost_full at levels 14..16 only.
- Mid-operation reset:
  - At level 3 with overflow set, assert rst for one cycle alongside wr_en: level = 0, empty = 1, overflow = 0, dout = 0, dout_valid = 0, and the write is discarded.
